// File: rtl/cr_su_ctl_mc_pkg.sv
// cr_su_ctl_mc_pkg: shared types, TLV layout constants and bip2 helper for the SU serializer
package cr_su_ctl_mc_pkg;
  typedef enum logic {IDLE, SEND} su_mc_st_e;
  localparam int SU_TLV_BYTES = 24;
  localparam int SU_TLV_LEN_W = 3;
  localparam logic [7:0] SU_TLV_TYPE_SCH = 8'h0A;
  localparam int SU_BYTES_W = 20;
  localparam int SU_FRAME_W = 19;
  localparam int SU_B_TYPE = 0;
  localparam int SU_B_LEN = 1;
  localparam int SU_B_SEQ = 2;
  localparam int SU_B_ENG = 3;
  localparam int SU_B_HLO = 5;
  localparam int SU_B_HMID = 6;
  localparam int SU_B_FLG = 7;
  localparam int SU_B_BOUT = 8;
  localparam int SU_B_BIN = 12;
  localparam int SU_B_BASIS = 16;
  localparam int SU_B_CHAN = 19;
  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [3:0]            tlv_eng_id;
    logic [7:0]            tlv_seq_num;
    logic [SU_FRAME_W-1:0] tlv_frame_num;
    logic [15:0]           rqe_sched_handle;
    logic [23:0]           basis;
    logic [SU_BYTES_W-1:0] bytes_in;
    logic [SU_BYTES_W-1:0] bytes_out;
  } sched_update_if_bus_t;
  typedef struct packed {
    logic                  last;
    logic [3:0]            eng;
    logic [7:0]            seq;
    logic [15:0]           handle;
    logic [23:0]           basis;
    logic [SU_BYTES_W-1:0] bytes_in;
    logic [SU_BYTES_W-1:0] bytes_out;
  } su_tlv_hold_t;
  typedef struct packed {
    logic                  last;
    logic [SU_FRAME_W-1:0] tlv_frame_num;
    logic [15:0]           handle;
    logic [7:0]            tlv_seq_num;
    logic [23:0]           basis;
    logic [SU_BYTES_W-1:0] bytes_in;
    logic [SU_BYTES_W-1:0] bytes_out;
  } su_hb_mc_entry_t;
  // bit 0 is parity of even bit positions, bit 1 parity of odd bit positions
  function automatic logic [1:0] ccx_bip2(input logic [63:0] w);
    logic [1:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) p[i % 2] ^= w[i];
    return p;
  endfunction
endpackage

// File: rtl/cr_su_ctl_mc_rr_arb.sv
// cr_su_rr_arb: round-robin arbiter, pointer moves past the winner on accept
module cr_su_rr_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         acc,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);
  logic [W-1:0] ptr;
  function automatic logic [W-1:0] wrap(input logic [W-1:0] p, input int i);
    int s = int'(p) + i;
    return W'(s >= N ? s - N : s);
  endfunction
  // scan from farthest to nearest so the first requester at or after ptr wins
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap(ptr, i)]) begin
        gnt = '0;
        gnt[wrap(ptr, i)] = 1'b1;
        gnt_id = wrap(ptr, i);
      end
    end
  end
  // advance priority to the channel after the accepted one
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (acc && |req) ptr <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + 1'b1;
  end
endmodule

// File: rtl/cr_su_ctl_mc.sv
// cr_su_ctl_mc: multi-channel scheduler-update to SCH TLV AXI-Stream serializer with history
module cr_su_ctl_mc
  import cr_su_ctl_mc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW_BYTES = 1,
  parameter int HB_DEPTH = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int HB_AW = $clog2(HB_DEPTH),
  localparam int HBW = 108 + CH_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  sched_update_if_bus_t      su_in [N_CH],
  output logic [N_CH-1:0]           su_ready,
  output logic                      su_axi_tvalid,
  input  logic                      su_axi_tready,
  output logic [8*DW_BYTES-1:0]     su_axi_tdata,
  output logic [1:0]                su_axi_tuser,
  output logic                      su_axi_tlast,
  input  logic                      hb_freeze,
  output logic [HBW-1:0]            su_hb [HB_DEPTH],
  output logic [HB_AW-1:0]          hb_wr_ptr,
  output logic                      su_agg_cnt_stb,
  output logic [15:0]               su_rec_cnt [N_CH]
);
  localparam int BEATS = SU_TLV_BYTES / DW_BYTES;
  localparam int BW = $clog2(BEATS);
  su_mc_st_e                 st;
  su_tlv_hold_t              hold, hold_d;
  su_hb_mc_entry_t           ent;
  logic [CH_W-1:0]           hold_ch, gnt_id;
  logic [BW-1:0]             beat;
  logic [N_CH-1:0]           req, gnt;
  logic                      acc, at_last, last_hs;
  logic [8*SU_TLV_BYTES-1:0] raw, tlv;
  // request vector from per-channel valids
  always_comb begin
    req = '0;
    for (int c = 0; c < N_CH; c++) req[c] = su_in[c].valid;
  end
  cr_su_rr_arb #(.N(N_CH), .W(CH_W)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req), .acc(acc), .gnt(gnt), .gnt_id(gnt_id)
  );
  assign acc = st == IDLE && |req;
  assign su_ready = st == IDLE ? gnt : '0;
  assign at_last = beat == BW'(BEATS - 1);
  assign last_hs = st == SEND && su_axi_tready && at_last;
  // split the granted record into the serializer image and the history payload
  always_comb begin
    hold_d.last = su_in[gnt_id].last;
    hold_d.eng = su_in[gnt_id].tlv_eng_id;
    hold_d.seq = su_in[gnt_id].tlv_seq_num;
    hold_d.handle = su_in[gnt_id].rqe_sched_handle;
    hold_d.basis = su_in[gnt_id].basis;
    hold_d.bytes_in = su_in[gnt_id].bytes_in;
    hold_d.bytes_out = su_in[gnt_id].bytes_out;
    ent.last = su_in[gnt_id].last;
    ent.tlv_frame_num = su_in[gnt_id].tlv_frame_num;
    ent.handle = su_in[gnt_id].rqe_sched_handle;
    ent.tlv_seq_num = su_in[gnt_id].tlv_seq_num;
    ent.basis = su_in[gnt_id].basis;
    ent.bytes_in = su_in[gnt_id].bytes_in;
    ent.bytes_out = su_in[gnt_id].bytes_out;
  end
  // TLV image with the bip field still zero
  always_comb begin
    raw = '0;
    raw[8*SU_B_TYPE +: 8] = SU_TLV_TYPE_SCH;
    raw[8*SU_B_LEN +: 8] = 8'(SU_TLV_LEN_W);
    raw[8*SU_B_SEQ +: 8] = hold.seq;
    raw[8*SU_B_ENG +: 8] = {4'b0, hold.eng};
    raw[8*SU_B_HLO +: 8] = {hold.handle[4:0], 3'b0};
    raw[8*SU_B_HMID +: 8] = hold.handle[12:5];
    raw[8*SU_B_FLG +: 8] = {2'b0, hold.last, 2'b0, hold.handle[15:13]};
    raw[8*SU_B_BOUT +: 24] = 24'(hold.bytes_out);
    raw[8*SU_B_BIN +: 24] = 24'(hold.bytes_in);
    raw[8*SU_B_BASIS +: 24] = hold.basis;
    raw[8*SU_B_CHAN +: 8] = 8'(hold_ch);
  end
  assign tlv = {raw[8*SU_TLV_BYTES-1:64], ccx_bip2(raw[63:0]), raw[61:0]};
  assign su_axi_tvalid = st == SEND;
  assign su_axi_tdata = st == SEND ? tlv[int'(beat)*8*DW_BYTES +: 8*DW_BYTES] : '0;
  assign su_axi_tuser = st != SEND ? 2'b00 : at_last ? 2'b10 : beat == '0 ? 2'b01 : 2'b00;
  assign su_axi_tlast = st == SEND && at_last;
  // serializer FSM: latch on accept, step beats on handshake, pulse stb after the last beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      hold <= '0;
      hold_ch <= '0;
      beat <= '0;
      su_agg_cnt_stb <= 1'b0;
    end else begin
      su_agg_cnt_stb <= last_hs;
      if (acc) begin
        hold <= hold_d;
        hold_ch <= gnt_id;
        beat <= '0;
        st <= SEND;
      end else if (st == SEND && su_axi_tready) begin
        beat <= at_last ? '0 : beat + 1'b1;
        st <= at_last ? IDLE : SEND;
      end
    end
  end
  // per-channel record counters and freezable circular history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_wr_ptr <= '0;
      for (int i = 0; i < HB_DEPTH; i++) su_hb[i] <= '0;
      for (int c = 0; c < N_CH; c++) su_rec_cnt[c] <= '0;
    end else if (acc) begin
      su_rec_cnt[gnt_id] <= su_rec_cnt[gnt_id] + 1'b1;
      if (!hb_freeze) begin
        su_hb[hb_wr_ptr] <= {gnt_id, ent};
        hb_wr_ptr <= hb_wr_ptr + 1'b1;
      end
    end
  end
endmodule
